i2c_cmd_arbiter: RTL and testbench
==================================

Name: i2c_cmd_arbiter

Overview:
- Shares one byte-level I2C master command engine among NUM_REQ requesters.
- Requesters issue byte commands: START, WRITE, READ_ACK, READ_NAK, STOP.
- Round-robin grant is locked for a whole transaction, from START until STOP completes or arbitration is lost.
- Sits between the bus-side requesters and the master's command/response port. Exactly one command is outstanding at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, I2C byte width.
- TIMEOUT_CYCLES, 1024, owner-idle limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_cmd_valid_i  in  NUM_REQ  per-requester command valid.
- req_cmd_i  in  3*NUM_REQ  per-requester command; slice r is [3r+2:3r].
- req_data_i  in  DATA_WIDTH*NUM_REQ  per-requester write byte.
- req_cmd_ready_o  out  NUM_REQ  command accepted this cycle (one-hot or zero).
- rsp_valid_o  out  NUM_REQ  one-cycle response pulse to one requester.
- rsp_status_o  out  2  shared; qualified by rsp_valid_o.
- rsp_data_o  out  DATA_WIDTH  shared read byte.
- grant_o  out  NUM_REQ  one-hot current owner; zero when free.
- mst_cmd_valid_o  out  1  command to master.
- mst_cmd_o  out  3  command to master.
- mst_data_o  out  DATA_WIDTH  write byte to master.
- mst_cmd_ready_i  in  1  master accepts command.
- mst_done_i  in  1  master completion pulse.
- mst_status_i  in  2  master completion status.
- mst_rdata_i  in  DATA_WIDTH  master read byte.

Behaviour:
- Command encoding: 0 START, 1 WRITE, 2 READ_ACK, 3 READ_NAK, 4 STOP; 5-7 illegal.
- Status encoding: 0 OK, 1 NAK, 2 ARB_LOST, 3 ERR.
- Reset:
  - All outputs 0; state IDLE; RR pointer 0.
  - Reset mid-transaction drops grant and mst_cmd_valid_o on the next edge; no STOP is issued.
- States:
  - IDLE:
    - Pick the first requester with valid high, searching from the RR pointer upward with wrap-around.
    - Candidate cmd START: ready pulses combinationally in the same cycle; command/data registered; grant_o set next edge; go ISSUE.
    - Candidate cmd non-START: ready pulses; ERR response one cycle later; no grant; RR pointer advances past it.
  - GRANT:
    - Owner only; all other readies stay 0.
    - Owner valid with legal cmd: ready pulses, command registered, go ISSUE.
    - Illegal cmd or START-while-owned: accepted; ERR response next cycle; stay GRANT. A repeated START is illegal; the owner must send STOP.
  - ISSUE: mst_cmd_valid_o held with stable cmd/data until mst_cmd_ready_i is sampled high; then go WAIT_RSP.
  - WAIT_RSP:
    - On mst_done_i: register status/data; pulse rsp_valid_o[owner] on the next cycle.
    - STOP completed, or status ARB_LOST: release grant and set RR pointer = owner+1 mod NUM_REQ; go IDLE.
    - Otherwise go GRANT. NAK keeps the grant; the owner must STOP.
- Latency:
  - Accept to mst_cmd_valid_o: 1 cycle.
  - mst_done_i to rsp_valid_o: 1 cycle.
  - Fresh arbitration is possible in the cycle after the release edge.
- Simultaneous requests: only one is granted; the others wait with ready low. Requesters must hold valid stable until ready.
- rsp_data_o is valid only for READ_ACK/READ_NAK; otherwise it is 0.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, a counter increments each cycle the owner's valid is low and clears on accept.
  - At TIMEOUT_CYCLES the arbiter itself issues STOP through ISSUE/WAIT_RSP.
  - It then pulses rsp_valid_o[owner] with ERR, releases, and advances RR.
  - An extra output timeout_o pulses for 1 cycle with that response.
- Undefined: no counter and no timeout_o port; the grant is held indefinitely.

Decomposition:
- Shared package i2c_arb_pkg: command enum, status enum, arbiter state enum, command/status width constants.
- One natural sub-module: rr_arbiter, the NUM_REQ round-robin selector with pointer input and one-hot output.

Test Plan:
- Req0 alone: START, WRITE 0xA5, STOP; master done OK each time -> three OK responses on rsp_valid_o[0]; grant_o=0001 throughout, then 0000; mst_cmd_o sequence 0,1,4 with data 0xA5.
- Req1 and req2 raise START in the same cycle with pointer 0 -> req1 granted; req2 ready held 0 until req1's STOP response; req2 granted on the following arbitration, pointer then 2.
- Owner READ_ACK, master returns 0x3C -> rsp_data_o=0x3C with status OK, 1 cycle after mst_done_i.
- Master returns ARB_LOST on START -> status 2 to owner; grant released without STOP; next requester granted.
- Req3 sends WRITE while unowned -> ERR response, no mst_cmd_valid_o, grant_o stays 0000.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: owner idles after START -> after 16 cycles a STOP is issued, ERR response, timeout_o pulse, grant released. Separately, rst_i asserted in WAIT_RSP -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// ============================================================================
// Module : i2c_arb_pkg
// Brief  : Shared command/status/state encodings for the I2C command arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_arb_pkg;

    localparam int c_cmd_w  = 3;
    localparam int c_stat_w = 2;
    localparam int c_st_w   = 2;

    typedef enum logic [c_cmd_w-1:0] {
        CMD_START    = 3'd0,
        CMD_WRITE    = 3'd1,
        CMD_READ_ACK = 3'd2,
        CMD_READ_NAK = 3'd3,
        CMD_STOP     = 3'd4
    } cmd_e;

    typedef enum logic [c_stat_w-1:0] {
        STAT_OK       = 2'd0,
        STAT_NAK      = 2'd1,
        STAT_ARB_LOST = 2'd2,
        STAT_ERR      = 2'd3
    } status_e;

    localparam logic [c_st_w-1:0] c_st_idle     = 2'd0;
    localparam logic [c_st_w-1:0] c_st_grant    = 2'd1;
    localparam logic [c_st_w-1:0] c_st_issue    = 2'd2;
    localparam logic [c_st_w-1:0] c_st_wait_rsp = 2'd3;

    function automatic logic is_legal_cmd(input logic [c_cmd_w-1:0] cmd);
        return (cmd <= CMD_STOP);
    endfunction

    function automatic logic is_read_cmd(input logic [c_cmd_w-1:0] cmd);
        return (cmd == CMD_READ_ACK) || (cmd == CMD_READ_NAK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_cmd_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin selector; first request at or above the
//          pointer wins, wrapping to the lowest index otherwise.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx
);

    logic [NUM_REQ-1:0] w_upper;
    logic [NUM_REQ-1:0] w_pick;
    logic               w_found;

    always_comb begin
        w_upper = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_upper[j] = i_req[j] && (IDX_W'(j) >= i_ptr);
        end
        // Nothing at/above the pointer means the search wraps to index 0.
        w_pick  = (|w_upper) ? w_upper : i_req;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_pick[j]) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_cmd_arbiter.sv
// ============================================================================
// Module : i2c_cmd_arbiter
// Brief  : Transaction-locked round-robin sharing of one byte-level I2C master
//          among NUM_REQ requesters. Optional owner-idle timeout is enabled by
//          defining I2C_ARB_TIMEOUT_EN (adds port timeout_o).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_cmd_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_cmd_valid_i,
    input  logic [c_cmd_w*NUM_REQ-1:0]    req_cmd_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_cmd_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [c_stat_w-1:0]           rsp_status_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          mst_cmd_valid_o,
    output logic [c_cmd_w-1:0]            mst_cmd_o,
    output logic [DATA_WIDTH-1:0]         mst_data_o,
`ifdef I2C_ARB_TIMEOUT_EN
    output logic                          timeout_o,
`endif
    input  logic                          mst_cmd_ready_i,
    input  logic                          mst_done_i,
    input  logic [c_stat_w-1:0]           mst_status_i,
    input  logic [DATA_WIDTH-1:0]         mst_rdata_i
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    logic [c_st_w-1:0]      r_state;
    logic [c_idx_w-1:0]     r_ptr;
    logic [c_idx_w-1:0]     r_owner;
    logic [NUM_REQ-1:0]     r_grant;
    logic                   r_mst_cmd_valid;
    logic [c_cmd_w-1:0]     r_mst_cmd;
    logic [DATA_WIDTH-1:0]  r_mst_data;
    logic [NUM_REQ-1:0]     r_rsp_valid;
    logic [c_stat_w-1:0]    r_rsp_status;
    logic [DATA_WIDTH-1:0]  r_rsp_data;

    logic [NUM_REQ-1:0]     w_arb_gnt;
    logic [c_idx_w-1:0]     w_arb_idx;
    logic [c_idx_w-1:0]     w_sel_idx;
    logic [c_cmd_w-1:0]     w_cmd;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [NUM_REQ-1:0]     w_ready;
    logic                   w_accept;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_tmr_w-1:0]     r_tmr;
    logic                   r_to_pend;
    logic                   r_timeout;
    assign timeout_o = r_timeout;
`endif

    function automatic logic [c_idx_w-1:0] f_next(input logic [c_idx_w-1:0] idx);
        return (idx == c_idx_w'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr (
        .i_req (req_cmd_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    always_comb begin
        w_sel_idx = (r_state == c_st_idle) ? w_arb_idx : r_owner;
        w_cmd     = '0;
        w_data    = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_sel_idx == c_idx_w'(r)) begin
                w_cmd  = req_cmd_i[r*c_cmd_w +: c_cmd_w];
                w_data = req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        // Ready is gated by reset so nothing is accepted while it is held.
        w_ready = '0;
        if (!rst_i) begin
            if (r_state == c_st_idle) begin
                w_ready = w_arb_gnt;
            end else if (r_state == c_st_grant) begin
                w_ready = r_grant & req_cmd_valid_i;
            end
        end
    end

    assign w_accept = |w_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= c_st_idle;
            r_ptr           <= '0;
            r_owner         <= '0;
            r_grant         <= '0;
            r_mst_cmd_valid <= 1'b0;
            r_mst_cmd       <= '0;
            r_mst_data      <= '0;
            r_rsp_valid     <= '0;
            r_rsp_status    <= '0;
            r_rsp_data      <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            r_tmr           <= '0;
            r_to_pend       <= 1'b0;
            r_timeout       <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
            if (r_state != c_st_grant || w_accept) begin
                r_tmr <= '0;
            end
`endif
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        if (w_cmd == CMD_START) begin
                            r_grant         <= w_arb_gnt;
                            r_owner         <= w_arb_idx;
                            r_mst_cmd_valid <= 1'b1;
                            r_mst_cmd       <= w_cmd;
                            r_mst_data      <= w_data;
                            r_state         <= c_st_issue;
                        end else begin
                            r_rsp_valid  <= w_arb_gnt;
                            r_rsp_status <= STAT_ERR;
                            r_rsp_data   <= '0;
                            r_ptr        <= f_next(w_arb_idx);
                        end
                    end
                end

                c_st_grant: begin
                    if (w_accept) begin
                        if (is_legal_cmd(w_cmd) && (w_cmd != CMD_START)) begin
                            r_mst_cmd_valid <= 1'b1;
                            r_mst_cmd       <= w_cmd;
                            r_mst_data      <= w_data;
                            r_state         <= c_st_issue;
                        end else begin
                            // A second START inside a transaction is refused.
                            r_rsp_valid  <= r_grant;
                            r_rsp_status <= STAT_ERR;
                            r_rsp_data   <= '0;
                        end
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (r_tmr == c_tmr_w'(TIMEOUT_CYCLES - 1)) begin
                        r_mst_cmd_valid <= 1'b1;
                        r_mst_cmd       <= CMD_STOP;
                        r_mst_data      <= '0;
                        r_to_pend       <= 1'b1;
                        r_state         <= c_st_issue;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
`endif
                end

                c_st_issue: begin
                    if (mst_cmd_ready_i) begin
                        r_mst_cmd_valid <= 1'b0;
                        r_state         <= c_st_wait_rsp;
                    end
                end

                c_st_wait_rsp: begin
                    if (mst_done_i) begin
                        r_rsp_valid  <= r_grant;
                        r_rsp_status <= mst_status_i;
                        r_rsp_data   <= is_read_cmd(r_mst_cmd) ? mst_rdata_i : '0;
                        if ((r_mst_cmd == CMD_STOP) || (mst_status_i == STAT_ARB_LOST)) begin
                            r_grant <= '0;
                            r_ptr   <= f_next(r_owner);
                            r_state <= c_st_idle;
                        end else begin
                            r_state <= c_st_grant;
                        end
`ifdef I2C_ARB_TIMEOUT_EN
                        // The forced STOP always reports ERR to the idle owner.
                        if (r_to_pend) begin
                            r_rsp_status <= STAT_ERR;
                            r_timeout    <= 1'b1;
                            r_to_pend    <= 1'b0;
                        end
`endif
                    end
                end

                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign req_cmd_ready_o = w_ready;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_status_o    = r_rsp_status;
    assign rsp_data_o      = r_rsp_data;
    assign grant_o         = r_grant;
    assign mst_cmd_valid_o = r_mst_cmd_valid;
    assign mst_cmd_o       = r_mst_cmd;
    assign mst_data_o      = r_mst_data;

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_arbiter.sv
// ============================================================================
// Module : tb_i2c_cmd_arbiter
// Brief  : Directed self-checking bench for i2c_cmd_arbiter (timeout case is
//          exercised when I2C_ARB_TIMEOUT_EN is defined).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_cmd_arbiter;
    import i2c_arb_pkg::*;

    localparam int NUM_REQ        = 4;
    localparam int DATA_WIDTH     = 8;
    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  req_cmd_valid_i;
    logic [11:0] req_cmd_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_cmd_ready_o;
    logic [3:0]  rsp_valid_o;
    logic [1:0]  rsp_status_o;
    logic [7:0]  rsp_data_o;
    logic [3:0]  grant_o;
    logic        mst_cmd_valid_o;
    logic [2:0]  mst_cmd_o;
    logic [7:0]  mst_data_o;
    logic        mst_cmd_ready_i;
    logic        mst_done_i;
    logic [1:0]  mst_status_i;
    logic [7:0]  mst_rdata_i;
`ifdef I2C_ARB_TIMEOUT_EN
    logic        timeout_o;
`endif

    logic [2:0]  cmd_a [NUM_REQ];
    logic [7:0]  dat_a [NUM_REQ];

    int n_cmp = 0;
    int n_err = 0;

    assign req_cmd_i  = {cmd_a[3], cmd_a[2], cmd_a[1], cmd_a[0]};
    assign req_data_i = {dat_a[3], dat_a[2], dat_a[1], dat_a[0]};

    always #5 clk = ~clk;

    i2c_cmd_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_cmd_valid_i (req_cmd_valid_i),
        .req_cmd_i       (req_cmd_i),
        .req_data_i      (req_data_i),
        .req_cmd_ready_o (req_cmd_ready_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_status_o    (rsp_status_o),
        .rsp_data_o      (rsp_data_o),
        .grant_o         (grant_o),
        .mst_cmd_valid_o (mst_cmd_valid_o),
        .mst_cmd_o       (mst_cmd_o),
        .mst_data_o      (mst_data_o),
`ifdef I2C_ARB_TIMEOUT_EN
        .timeout_o       (timeout_o),
`endif
        .mst_cmd_ready_i (mst_cmd_ready_i),
        .mst_done_i      (mst_done_i),
        .mst_status_i    (mst_status_i),
        .mst_rdata_i     (mst_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command, check the same-cycle ready, let the edge accept it.
    task automatic send(input int r, input logic [2:0] cmd, input logic [7:0] data,
                        input logic [3:0] exp_rdy, input string tag);
        req_cmd_valid_i[r] = 1'b1;
        cmd_a[r] = cmd;
        dat_a[r] = data;
        #1;
        check_eq({tag, "/ready"}, req_cmd_ready_o, exp_rdy);
        tick();
        req_cmd_valid_i[r] = 1'b0;
    endtask

    task automatic master(input logic [2:0] exp_cmd, input logic [7:0] exp_data, input int hold,
                          input logic [1:0] st, input logic [7:0] rd, input string tag);
        repeat (hold) tick();
        check_eq({tag, "/mvalid"}, mst_cmd_valid_o, 1);
        check_eq({tag, "/mcmd"}, mst_cmd_o, exp_cmd);
        check_eq({tag, "/mdata"}, mst_data_o, exp_data);
        mst_cmd_ready_i = 1'b1;
        tick();
        mst_cmd_ready_i = 1'b0;
        check_eq({tag, "/mvalid_drop"}, mst_cmd_valid_o, 0);
        mst_done_i   = 1'b1;
        mst_status_i = st;
        mst_rdata_i  = rd;
        tick();
        mst_done_i   = 1'b0;
        mst_rdata_i  = 8'h00;
    endtask

    task automatic expect_rsp(input logic [3:0] v, input logic [1:0] s, input logic [7:0] d,
                              input logic [3:0] g, input string tag);
        check_eq({tag, "/rsp_valid"}, rsp_valid_o, v);
        check_eq({tag, "/rsp_status"}, rsp_status_o, s);
        check_eq({tag, "/rsp_data"}, rsp_data_o, d);
        check_eq({tag, "/grant"}, grant_o, g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_i = 1'b1;
        req_cmd_valid_i = '0;
        mst_cmd_ready_i = 1'b0;
        mst_done_i = 1'b0;
        mst_status_i = '0;
        mst_rdata_i = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_a[i] = '0;
            dat_a[i] = '0;
        end
        repeat (3) tick();
        req_cmd_valid_i[0] = 1'b1;
        #1;
        check_eq("rst/ready", req_cmd_ready_o, 0);
        check_eq("rst/grant", grant_o, 0);
        check_eq("rst/mvalid", mst_cmd_valid_o, 0);
        check_eq("rst/rsp_valid", rsp_valid_o, 0);
        req_cmd_valid_i[0] = 1'b0;
        rst_i = 1'b0;
        tick();

        // Req0 alone: START, WRITE 0xA5 (master stalls 2 cycles), STOP.
        send(0, CMD_START, 8'h00, 4'b0001, "t1_start");
        check_eq("t1_start/grant", grant_o, 4'b0001);
        master(CMD_START, 8'h00, 0, STAT_OK, 8'h00, "t1_start");
        expect_rsp(4'b0001, STAT_OK, 8'h00, 4'b0001, "t1_start");
        send(0, CMD_WRITE, 8'hA5, 4'b0001, "t1_wr");
        master(CMD_WRITE, 8'hA5, 2, STAT_OK, 8'h00, "t1_wr");
        expect_rsp(4'b0001, STAT_OK, 8'h00, 4'b0001, "t1_wr");
        send(0, CMD_STOP, 8'h00, 4'b0001, "t1_stop");
        master(CMD_STOP, 8'h00, 0, STAT_OK, 8'h00, "t1_stop");
        expect_rsp(4'b0001, STAT_OK, 8'h00, 4'b0000, "t1_stop");
        tick();
        check_eq("t1/rsp_pulse_end", rsp_valid_o, 0);

        // Req1 and req2 START together; req1 wins, req2 waits until release.
        req_cmd_valid_i[2] = 1'b1;
        cmd_a[2] = CMD_START;
        send(1, CMD_START, 8'h00, 4'b0010, "t2_r1_start");
        check_eq("t2/r2_wait_issue", req_cmd_ready_o, 0);
        master(CMD_START, 8'h00, 0, STAT_OK, 8'h00, "t2_r1_start");
        expect_rsp(4'b0010, STAT_OK, 8'h00, 4'b0010, "t2_r1_start");
        check_eq("t2/r2_wait_grant", req_cmd_ready_o, 0);
        send(1, CMD_STOP, 8'h00, 4'b0010, "t2_r1_stop");
        master(CMD_STOP, 8'h00, 0, STAT_OK, 8'h00, "t2_r1_stop");
        expect_rsp(4'b0010, STAT_OK, 8'h00, 4'b0000, "t2_r1_stop");
        send(2, CMD_START, 8'h00, 4'b0100, "t2_r2_start");
        check_eq("t2_r2_start/grant", grant_o, 4'b0100);
        master(CMD_START, 8'h00, 0, STAT_OK, 8'h00, "t2_r2_start");
        expect_rsp(4'b0100, STAT_OK, 8'h00, 4'b0100, "t2_r2_start");

        // Read returns 0x3C; a NAKed write returns status 1, data 0, grant kept.
        send(2, CMD_READ_ACK, 8'h00, 4'b0100, "t3_rd");
        master(CMD_READ_ACK, 8'h00, 0, STAT_OK, 8'h3C, "t3_rd");
        expect_rsp(4'b0100, STAT_OK, 8'h3C, 4'b0100, "t3_rd");
        send(2, CMD_WRITE, 8'h11, 4'b0100, "t3_nak");
        master(CMD_WRITE, 8'h11, 0, STAT_NAK, 8'hFF, "t3_nak");
        expect_rsp(4'b0100, STAT_NAK, 8'h00, 4'b0100, "t3_nak");

        // Illegal code and repeated START while owned: ERR, grant kept.
        send(2, 3'd7, 8'h00, 4'b0100, "t3_ill");
        expect_rsp(4'b0100, STAT_ERR, 8'h00, 4'b0100, "t3_ill");
        check_eq("t3_ill/mvalid", mst_cmd_valid_o, 0);
        send(2, CMD_START, 8'h00, 4'b0100, "t3_restart");
        expect_rsp(4'b0100, STAT_ERR, 8'h00, 4'b0100, "t3_restart");
        check_eq("t3_restart/mvalid", mst_cmd_valid_o, 0);
        send(2, CMD_STOP, 8'h00, 4'b0100, "t3_stop");
        master(CMD_STOP, 8'h00, 0, STAT_OK, 8'h00, "t3_stop");
        expect_rsp(4'b0100, STAT_OK, 8'h00, 4'b0000, "t3_stop");

        // Req3 WRITE while unowned (pointer now 3): ERR, no master command.
        send(3, CMD_WRITE, 8'h55, 4'b1000, "t5_wr");
        expect_rsp(4'b1000, STAT_ERR, 8'h00, 4'b0000, "t5_wr");
        check_eq("t5_wr/mvalid", mst_cmd_valid_o, 0);

        // Pointer 0: req0 beats waiting req1; ARB_LOST releases without STOP.
        req_cmd_valid_i[1] = 1'b1;
        cmd_a[1] = CMD_START;
        send(0, CMD_START, 8'h00, 4'b0001, "t4_r0");
        master(CMD_START, 8'h00, 0, STAT_ARB_LOST, 8'h00, "t4_r0");
        expect_rsp(4'b0001, STAT_ARB_LOST, 8'h00, 4'b0000, "t4_r0");
        send(1, CMD_START, 8'h00, 4'b0010, "t4_r1");
        check_eq("t4_r1/grant", grant_o, 4'b0010);
        master(CMD_START, 8'h00, 0, STAT_OK, 8'h00, "t4_r1");
        expect_rsp(4'b0010, STAT_OK, 8'h00, 4'b0010, "t4_r1");

        // Reset in WAIT_RSP drops grant immediately and restores pointer 0.
        send(1, CMD_STOP, 8'h00, 4'b0010, "t6_stop");
        mst_cmd_ready_i = 1'b1;
        tick();
        mst_cmd_ready_i = 1'b0;
        rst_i = 1'b1;
        tick();
        check_eq("t6_rst/grant", grant_o, 0);
        check_eq("t6_rst/mvalid", mst_cmd_valid_o, 0);
        check_eq("t6_rst/mcmd", mst_cmd_o, 0);
        check_eq("t6_rst/rsp_valid", rsp_valid_o, 0);
        rst_i = 1'b0;
        tick();
        req_cmd_valid_i[3] = 1'b1;
        cmd_a[3] = CMD_START;
        send(0, CMD_START, 8'h00, 4'b0001, "t6_r0");
        master(CMD_START, 8'h00, 0, STAT_OK, 8'h00, "t6_r0");
        expect_rsp(4'b0001, STAT_OK, 8'h00, 4'b0001, "t6_r0");
        send(0, CMD_STOP, 8'h00, 4'b0001, "t6_r0_stop");
        master(CMD_STOP, 8'h00, 0, STAT_OK, 8'h00, "t6_r0_stop");
        expect_rsp(4'b0001, STAT_OK, 8'h00, 4'b0000, "t6_r0_stop");
        send(3, CMD_START, 8'h00, 4'b1000, "t7_r3");
        master(CMD_START, 8'h00, 0, STAT_OK, 8'h00, "t7_r3");
        expect_rsp(4'b1000, STAT_OK, 8'h00, 4'b1000, "t7_r3");

`ifdef I2C_ARB_TIMEOUT_EN
        // Owner idles: 16 GRANT edges later the arbiter issues its own STOP.
        n = 0;
        while (!mst_cmd_valid_o && n < 40) begin
            tick();
            n++;
        end
        check_eq("t7_to/idle_cycles", n, 16);
        master(CMD_STOP, 8'h00, 0, STAT_OK, 8'h00, "t7_to");
        expect_rsp(4'b1000, STAT_ERR, 8'h00, 4'b0000, "t7_to");
        check_eq("t7_to/timeout", timeout_o, 1);
        tick();
        check_eq("t7_to/timeout_end", timeout_o, 0);
`else
        // Without the timeout the idle owner keeps the grant indefinitely.
        n = 0;
        repeat (20) begin
            tick();
            n++;
        end
        check_eq("t7_hold/grant", grant_o, 4'b1000);
        check_eq("t7_hold/mvalid", mst_cmd_valid_o, 0);
        send(3, CMD_STOP, 8'h00, 4'b1000, "t7_stop");
        master(CMD_STOP, 8'h00, 0, STAT_OK, 8'h00, "t7_stop");
        expect_rsp(4'b1000, STAT_OK, 8'h00, 4'b0000, "t7_stop");
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
